shift_seq: RTL and testbench
============================

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 3, width of the shift-count field; maximum count is 2^CNT_W-1.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset; sampled only on the rising edge of clk.
REQ-004 SHALL have port in_valid  input  1  request carries a valid word and count.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port in_data  input  4  word to be loaded into the downstream 4-bit shift register.
REQ-007 SHALL have port in_count  input  CNT_W  number of shift-enable cycles to issue after the load.
REQ-008 SHALL have port load  output  1  parallel-load strobe to the downstream shift register.
REQ-009 SHALL have port ena  output  1  shift-enable strobe to the downstream shift register.
REQ-010 SHALL have port data  output  4  parallel-load word to the downstream shift register.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a request completes.

Function
REQ-013 SHALL implement the states IDLE, LOAD, SHIFT and DONE, one-hot or encoded.
REQ-014 SHALL drive in_ready=1 only in IDLE; a handshake occurs on any rising edge where in_valid and in_ready are both 1.
REQ-015 On a handshake, SHALL register in_data into data and in_count into a remaining-count register, and SHALL move to LOAD.
REQ-016 In LOAD, SHALL drive load=1 and ena=0 for exactly one cycle; next state SHALL be DONE if count==0, otherwise SHIFT.
REQ-017 In SHIFT, SHALL drive ena=1 and load=0, and SHALL decrement the remaining count each cycle; SHALL move to DONE on the cycle the remaining count is 1.
REQ-018 In DONE, SHALL drive done=1 for exactly one cycle, then SHALL return to IDLE.
REQ-019 load and ena SHALL never be high in the same cycle.
REQ-020 Timing for a handshake at edge k with count N: load SHALL be high in cycle k+1, ena SHALL be high in cycles k+2..k+1+N, done SHALL be high in cycle k+2+N, and in_ready SHALL be high again in cycle k+3+N.
REQ-021 data SHALL hold the last accepted word between requests; in_data changes outside a handshake SHALL be ignored.
REQ-022 in_valid while not IDLE SHALL be ignored; no request is queued.
REQ-023 count = 2^CNT_W-1 SHALL issue exactly that many ena cycles, with no wrap of the counter.
REQ-024 All outputs SHALL be registered or decoded only from registered state, with no combinational path from inputs to outputs.

Reset
REQ-025 reset SHALL take priority over all other inputs, including a handshake in the same cycle.
REQ-026 After reset: state=IDLE, in_ready=1, load=0, ena=0, busy=0, done=0, data=4'b0000, remaining count=0.
REQ-027 A reset during LOAD, SHIFT or DONE SHALL abandon the request with no done pulse, and outputs SHALL take their reset values on the next cycle.

Configuration
REQ-028 When the macro SHIFT_SEQ_ABORT_EN is defined, SHALL add the port abort (input, 1 bit); abort=1 in LOAD or SHIFT SHALL force IDLE on the next edge with load=0, ena=0 and no done pulse, while data and in_ready behave as after completion.
REQ-029 When SHIFT_SEQ_ABORT_EN is not defined, the abort port and its logic SHALL be absent, and behaviour SHALL be exactly REQ-013..REQ-027.

Verification
REQ-030 Reset then idle: assert reset for 2 cycles -> all outputs match REQ-026; in_ready=1.
REQ-031 Single request: in_data=4'b1011, in_count=3 -> load for 1 cycle with data=1011, then ena for 3 cycles, then done for 1 cycle; busy high for 5 cycles.
REQ-032 Zero count: in_data=4'b1100, in_count=0 -> load for 1 cycle, then done the next cycle, and ena is never asserted.
REQ-033 Back-to-back requests: in_valid held high with 1011/2 then 0110/7 -> second handshake occurs only in the cycle after the first done; ena total = 9 cycles; data=0110 after the second load.
REQ-034 Mid-operation disturbance: reset asserted in the 2nd ena cycle of a count-5 request -> no done; IDLE the next cycle; data=0000.
REQ-035 With SHIFT_SEQ_ABORT_EN: abort in the 1st ena cycle -> ena=0 the next cycle, no done, in_ready=1, data keeps the loaded word.

Source files
------------

// File: rtl/shift_seq.sv
// shift_seq: load/shift sequencer for a downstream 4-bit shift register.
// A request (word + shift count) is accepted in IDLE. The block then issues one
// parallel-load strobe, followed by `count` shift-enable strobes, then a one-cycle
// done pulse. All outputs are decoded from registered state only.
//
// Optional feature: define SHIFT_SEQ_ABORT_EN to add an `abort` input that
// cancels a request in LOAD or SHIFT. The cancelled request gives no done pulse.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for a request; in_ready=1
//   ST_LOAD  | one-cycle parallel-load strobe with the captured word
//   ST_SHIFT | shift-enable strobe; remaining count counts down to 1
//   ST_DONE  | one-cycle completion pulse, then back to IDLE

module shift_seq #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic [CNT_W-1:0] in_count,
    output logic             load,
    output logic             ena,
    output logic [3:0]       data,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] rem_q;
    logic             accept;
    logic             cancel;

    assign accept = (state_q == ST_IDLE) && in_valid;

`ifdef SHIFT_SEQ_ABORT_EN
    assign cancel = abort && ((state_q == ST_LOAD) || (state_q == ST_SHIFT));
`else
    assign cancel = 1'b0;
`endif

    // Next-state selection. SHIFT leaves on the cycle where the remaining count
    // is 1, so it issues exactly `count` enables and the counter never wraps.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid) state_d = ST_LOAD;
            ST_LOAD:  state_d = (rem_q == '0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (rem_q == CNT_W'(1)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (cancel) state_d = ST_IDLE;
    end

    // State register. Reset has priority over a same-cycle handshake.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Capture the word and count on a handshake, then count down while shifting.
    // data is kept after completion or abort so that it holds the last accepted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= 4'b0000;
            rem_q <= '0;
        end else if (accept) begin
            data  <= in_data;
            rem_q <= in_count;
        end else if ((state_q == ST_SHIFT) && !cancel) begin
            rem_q <= rem_q - CNT_W'(1);
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign load     = (state_q == ST_LOAD);
    assign ena      = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq. The reference model tracks each accepted request only
// by the number of edges since its handshake (its phase). Phase 0 is the load
// cycle. Phases 1..N are the enable cycles. Phase N+1 is the done cycle.
// Directed scenarios pin totals with hand-computed literals. A randomized run
// follows them. Define SHIFT_SEQ_ABORT_EN to include the abort scenarios.

module tb_shift_seq;

    localparam int CNT_W = 3;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic [CNT_W-1:0] in_count;
    logic             load;
    logic             ena;
    logic [3:0]       data;
    logic             busy;
    logic             done;
    logic             abort_m;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         e_cnt = 0;
    int         hs_e  = 0;
    int         req_n = 0;
    bit         act   = 1'b0;
    logic [3:0] mdata = 4'b0000;

    // running totals of observed strobes, for the literal checks
    int load_n = 0;
    int ena_n  = 0;
    int done_n = 0;
    int busy_n = 0;

    shift_seq #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort    (abort_m),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_count (in_count),
        .load     (load),
        .ena      (ena),
        .data     (data),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model update on every edge. p_old is the phase of the cycle ending at this edge.
    always @(posedge clk) begin
        int p_old;
        e_cnt = e_cnt + 1;
        p_old = e_cnt - 1 - hs_e;
        if (reset) begin
            act   = 1'b0;
            mdata = 4'b0000;
        end else if (act) begin
            if (abort_m && p_old <= req_n) act = 1'b0;
            else if (p_old == req_n + 1)   act = 1'b0;
        end else if (in_valid) begin
            act   = 1'b1;
            hs_e  = e_cnt;
            req_n = int'(in_count);
            mdata = in_data;
        end
    end

    task automatic chk(input string name, input int act_v, input int exp_v);
        checks = checks + 1;
        if (act_v != exp_v) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act_v, exp_v);
        end
    endtask

    // Advance one clock and check all outputs against the model on the falling edge.
    task automatic cycle();
        int p;
        @(posedge clk);
        @(negedge clk);
        p = e_cnt - hs_e;
        chk("in_ready", int'(in_ready), int'(!act));
        chk("busy",     int'(busy),     int'(act));
        chk("load",     int'(load),     int'(act && p == 0));
        chk("ena",      int'(ena),      int'(act && p >= 1 && p <= req_n));
        chk("done",     int'(done),     int'(act && p == req_n + 1));
        chk("data",     int'(data),     int'(mdata));
        chk("load_ena_excl", int'(load && ena), 0);
        load_n = load_n + int'(load);
        ena_n  = ena_n  + int'(ena);
        done_n = done_n + int'(done);
        busy_n = busy_n + int'(busy);
    endtask

    initial begin
        int l0, e0, d0, b0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'b0000;
        in_count = '0;
        abort_m  = 1'b0;

        // Reset for two cycles. Drive in_valid high to show that reset wins.
        in_valid = 1'b1;
        in_data  = 4'b1111;
        cycle();
        cycle();
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_load",  int'(load), 0);
        chk("rst_ena",   int'(ena), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_data",  int'(data), 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        cycle();

        // Single request: 1011, count 3.
        l0 = load_n; e0 = ena_n; d0 = done_n; b0 = busy_n;
        in_valid = 1'b1; in_data = 4'b1011; in_count = 3'd3;
        cycle();
        chk("single_load_data", int'(data), 4'b1011);
        in_valid = 1'b0; in_data = 4'b0101;
        repeat (7) cycle();
        chk("single_load_n", load_n - l0, 1);
        chk("single_ena_n",  ena_n - e0, 3);
        chk("single_done_n", done_n - d0, 1);
        chk("single_busy_n", busy_n - b0, 5);
        chk("single_hold_data", int'(data), 4'b1011);

        // Zero count: 1100, count 0.
        l0 = load_n; e0 = ena_n; d0 = done_n; b0 = busy_n;
        in_valid = 1'b1; in_data = 4'b1100; in_count = 3'd0;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("zero_done_now", int'(done), 1);
        repeat (3) cycle();
        chk("zero_load_n", load_n - l0, 1);
        chk("zero_ena_n",  ena_n - e0, 0);
        chk("zero_done_n", done_n - d0, 1);
        chk("zero_busy_n", busy_n - b0, 2);

        // Back-to-back: valid held high with 1011/2, then 0110/7.
        l0 = load_n; e0 = ena_n; d0 = done_n;
        in_valid = 1'b1; in_data = 4'b1011; in_count = 3'd2;
        cycle();
        in_data = 4'b0110; in_count = 3'd7;
        repeat (4) cycle();
        chk("b2b_ready_gap", int'(in_ready), 1);
        cycle();
        chk("b2b_second_load", int'(load), 1);
        chk("b2b_data", int'(data), 4'b0110);
        in_valid = 1'b0;
        repeat (12) cycle();
        chk("b2b_load_n", load_n - l0, 2);
        chk("b2b_ena_n",  ena_n - e0, 9);
        chk("b2b_done_n", done_n - d0, 2);

        // Reset in the 2nd enable cycle of a count-5 request.
        e0 = ena_n; d0 = done_n;
        in_valid = 1'b1; in_data = 4'b1110; in_count = 3'd5;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("mid_ena_2nd", int'(ena), 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_ready", int'(in_ready), 1);
        chk("mid_data",  int'(data), 0);
        chk("mid_ena",   int'(ena), 0);
        repeat (4) cycle();
        chk("mid_ena_n",  ena_n - e0, 2);
        chk("mid_done_n", done_n - d0, 0);

`ifdef SHIFT_SEQ_ABORT_EN
        // Abort in the 1st enable cycle.
        e0 = ena_n; d0 = done_n;
        in_valid = 1'b1; in_data = 4'b1001; in_count = 3'd4;
        cycle();
        in_valid = 1'b0;
        cycle();
        abort_m = 1'b1;
        cycle();
        abort_m = 1'b0;
        chk("abort_ena",   int'(ena), 0);
        chk("abort_ready", int'(in_ready), 1);
        chk("abort_data",  int'(data), 4'b1001);
        repeat (4) cycle();
        chk("abort_ena_n",  ena_n - e0, 1);
        chk("abort_done_n", done_n - d0, 0);
`endif

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 49) == 0);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 4'($urandom);
            in_count = CNT_W'($urandom);
`ifdef SHIFT_SEQ_ABORT_EN
            abort_m  = ($urandom_range(0, 11) == 0);
`endif
            cycle();
        end
        reset = 1'b0; in_valid = 1'b0; abort_m = 1'b0;
        repeat (12) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
